// File: rtl/hamming_serial_driver.sv
// Host-side driver for a sequential Hamming-distance core: accepts one operand pair,
// pulses the core reset, streams CC chunks LSB-first, then hands back the result.
module hamming_serial_driver #(
  parameter  int N  = 8,
  parameter  int CC = N,
  localparam int M  = N / CC,
  localparam int OW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  g_word,
  input  logic [N-1:0]  e_word,
  output logic          core_rst,
  output logic [M-1:0]  g_input,
  output logic [M-1:0]  e_input,
  input  logic [OW-1:0] core_o,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res
);

  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if ((N % CC) != 0) begin : g_cc_check
      $error("hamming_serial_driver: N must be a multiple of CC");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRST   = 3'd1,
    S_SHIFT  = 3'd2,
    S_CAP    = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    g_sh_q, g_sh_d;
  logic [N-1:0]    e_sh_q, e_sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            core_rst_q, core_rst_d;
  logic [M-1:0]    g_input_q, g_input_d;
  logic [M-1:0]    e_input_q, e_input_d;
  logic            res_valid_q, res_valid_d;
  logic [OW-1:0]   res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_CRST;
        else          state_d = S_IDLE;
      end
      S_CRST:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) state_d = S_CAP;
        else                   state_d = S_SHIFT;
      end
      S_CAP:   state_d = S_RESULT;
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
        else           state_d = S_RESULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered, so each
  // chunk appears exactly during its SHIFT cycle; the shadows shift right by M.
  always_comb begin
    g_sh_d      = g_sh_q;
    e_sh_d      = e_sh_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    g_input_d   = '0;
    e_input_d   = '0;
    core_rst_d  = (state_d == S_CRST);
    res_valid_d = (state_d == S_RESULT);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          g_sh_d = g_word;
          e_sh_d = e_word;
        end else begin
          g_sh_d = g_sh_q;
          e_sh_d = e_sh_q;
        end
      end
      S_CRST: begin
        cnt_d     = '0;
        g_input_d = g_sh_q[M-1:0];
        e_input_d = e_sh_q[M-1:0];
        g_sh_d    = g_sh_q >> M;
        e_sh_d    = e_sh_q >> M;
      end
      S_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d     = cnt_q + CNT_ONE;
          g_input_d = g_sh_q[M-1:0];
          e_input_d = e_sh_q[M-1:0];
          g_sh_d    = g_sh_q >> M;
          e_sh_d    = e_sh_q >> M;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CAP:    res_d = core_o;
      S_RESULT: res_d = res_q;
      default:  res_d = res_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_sh_q      <= '0;
      e_sh_q      <= '0;
      cnt_q       <= '0;
      core_rst_q  <= 1'b1;
      g_input_q   <= '0;
      e_input_q   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      g_sh_q      <= g_sh_d;
      e_sh_q      <= e_sh_d;
      cnt_q       <= cnt_d;
      core_rst_q  <= core_rst_d;
      g_input_q   <= g_input_d;
      e_input_q   <= e_input_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign core_rst  = core_rst_q;
  assign g_input   = g_input_q;
  assign e_input   = e_input_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;

endmodule

// File: tb/tb_hamming_serial_driver.sv
// Self-checking bench: two driver instances (CC=8 and CC=4) each feeding a
// behavioural accumulate-popcount core; results checked against popcount(G^E).
module tb_hamming_serial_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // CC = 8 instance
  logic       iv8 = 1'b0, rr8 = 1'b0;
  logic [7:0] g8 = 8'h00, e8 = 8'h00;
  logic       ir8, crst8, rv8;
  logic [0:0] gi8, ei8;
  logic [3:0] co8, res8;
  logic [3:0] acc8 = 4'd0;

  hamming_serial_driver #(.N(8), .CC(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .g_word(g8), .e_word(e8), .core_rst(crst8), .g_input(gi8), .e_input(ei8),
    .core_o(co8), .res_valid(rv8), .res_ready(rr8), .res(res8)
  );

  // CC = 4 instance (M = 2)
  logic       iv4 = 1'b0, rr4 = 1'b0;
  logic [7:0] g4 = 8'h00, e4 = 8'h00;
  logic       ir4, crst4, rv4;
  logic [1:0] gi4, ei4;
  logic [3:0] co4, res4;
  logic [3:0] acc4 = 4'd0;

  hamming_serial_driver #(.N(8), .CC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .g_word(g4), .e_word(e4), .core_rst(crst4), .g_input(gi4), .e_input(ei4),
    .core_o(co4), .res_valid(rv4), .res_ready(rr4), .res(res4)
  );

  // Core model: clears on core_rst, otherwise adds the differing bits of each chunk.
  always @(posedge clk) begin
    if (crst8) acc8 <= 4'd0;
    else       acc8 <= acc8 + 4'($countones(gi8 ^ ei8));
    if (crst4) acc4 <= 4'd0;
    else       acc4 <= acc4 + 4'($countones(gi4 ^ ei4));
  end
  assign co8 = acc8;
  assign co4 = acc4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job8(input logic [7:0] g, input logic [7:0] e, input int hold);
    logic [3:0] exp;
    logic [7:0] gs, es;
    int n;
    exp = 4'($countones(g ^ e));
    checks++;
    if (ir8 !== 1'b1) begin
      errors++; $display("FAIL idle_ready: in_ready=%b expected 1", ir8);
    end
    iv8 = 1'b1; g8 = g; e8 = e;
    step();
    iv8 = 1'b0; g8 = 8'($urandom); e8 = 8'($urandom);
    checks++;
    if (crst8 !== 1'b1 || gi8 !== 1'b0 || ei8 !== 1'b0 || ir8 !== 1'b0) begin
      errors++;
      $display("FAIL crst_cycle: core_rst=%b g=%b e=%b in_ready=%b expected 1 0 0 0", crst8, gi8, ei8, ir8);
    end
    gs = 8'h00; es = 8'h00; n = 0;
    while (rv8 !== 1'b1 && n < 40) begin
      step();
      n++;
      if (n <= 8) begin
        gs[n-1] = gi8[0];
        es[n-1] = ei8[0];
      end
    end
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL latency8: got %0d edges expected 10", n);
    end
    checks++;
    if (gs !== g || es !== e) begin
      errors++; $display("FAIL chunks8: g=%h e=%h expected %h %h", gs, es, g, e);
    end
    checks++;
    if (res8 !== exp) begin
      errors++; $display("FAIL res8: got %0d expected %0d (G=%h E=%h)", res8, exp, g, e);
    end
    for (int i = 0; i < hold; i++) begin
      iv8 = 1'($urandom);
      step();
      checks++;
      if (rv8 !== 1'b1 || res8 !== exp || ir8 !== 1'b0) begin
        errors++;
        $display("FAIL hold: res_valid=%b res=%0d in_ready=%b expected 1 %0d 0", rv8, res8, ir8, exp);
      end
    end
    iv8 = 1'b0; rr8 = 1'b1;
    step();
    rr8 = 1'b0;
    checks++;
    if (rv8 !== 1'b0 || ir8 !== 1'b1 || res8 !== exp) begin
      errors++;
      $display("FAIL release: res_valid=%b in_ready=%b res=%0d expected 0 1 %0d", rv8, ir8, res8, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (crst8 !== 1'b1 || gi8 !== 1'b0 || ei8 !== 1'b0 || ir8 !== 1'b0 || rv8 !== 1'b0 || res8 !== 4'd0) begin
      errors++;
      $display("FAIL reset_vals: crst=%b g=%b e=%b rdy=%b rv=%b res=%0d expected 1 0 0 0 0 0",
               crst8, gi8, ei8, ir8, rv8, res8);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir8 !== 1'b1 || crst8 !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready=%b core_rst=%b expected 1 1", ir8, crst8);
    end
    step();
    checks++;
    if (crst8 !== 1'b0) begin
      errors++; $display("FAIL core_rst_drop: got %b expected 0", crst8);
    end
  endtask

  task automatic test_directed();
    do_job8(8'hA9, 8'h7B, 0);
    do_job8(8'h74, 8'h9D, 0);
    do_job8(8'hAA, 8'hAA, 0);
    do_job8(8'hFF, 8'h00, 0);
  endtask

  task automatic test_backpressure();
    do_job8(8'h74, 8'h9D, 5);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      do_job8(8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    iv8 = 1'b1; g8 = 8'hFF; e8 = 8'h00;
    step();
    iv8 = 1'b0;
    repeat (4) step();
    checks++;
    if (gi8 !== 1'b1) begin
      errors++; $display("FAIL chunk3: g_input=%b expected 1", gi8);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (crst8 !== 1'b1 || gi8 !== 1'b0 || ei8 !== 1'b0 || ir8 !== 1'b0 || rv8 !== 1'b0 || res8 !== 4'd0) begin
      errors++;
      $display("FAIL midjob_reset: crst=%b g=%b e=%b rdy=%b rv=%b res=%0d expected 1 0 0 0 0 0",
               crst8, gi8, ei8, ir8, rv8, res8);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rv8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL discarded_job: res_valid seen %0d times expected 0", seen);
    end
    do_job8(8'h74, 8'h9D, 0);
  endtask

  task automatic test_cc4();
    logic [7:0] g, e, gs, es;
    logic [1:0] first [4];
    logic [3:0] exp;
    int n;
    for (int j = 0; j < 4; j++) begin
      g = (j == 0) ? 8'hA9 : 8'($urandom);
      e = (j == 0) ? 8'h7B : 8'($urandom);
      exp = 4'($countones(g ^ e));
      iv4 = 1'b1; g4 = g; e4 = e;
      step();
      iv4 = 1'b0;
      gs = 8'h00; es = 8'h00; n = 0;
      while (rv4 !== 1'b1 && n < 40) begin
        step();
        n++;
        if (n <= 4) begin
          gs[2*(n-1) +: 2] = gi4;
          es[2*(n-1) +: 2] = ei4;
          if (j == 0) first[n-1] = gi4;
        end
      end
      checks++;
      if (n !== 6) begin
        errors++; $display("FAIL latency4: got %0d edges expected 6", n);
      end
      checks++;
      if (gs !== g || es !== e) begin
        errors++; $display("FAIL chunks4: g=%h e=%h expected %h %h", gs, es, g, e);
      end
      checks++;
      if (res4 !== exp) begin
        errors++; $display("FAIL res4: got %0d expected %0d", res4, exp);
      end
      if (j == 0) begin
        checks++;
        if (first[0] !== 2'b01 || first[1] !== 2'b10 || first[2] !== 2'b10 || first[3] !== 2'b10) begin
          errors++;
          $display("FAIL chunk_order4: got %b %b %b %b expected 01 10 10 10",
                   first[0], first[1], first[2], first[3]);
        end
      end
      rr4 = 1'b1;
      step();
      rr4 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] gp [3] = '{8'hA9, 8'h74, 8'hAA};
    logic [7:0] ep [3] = '{8'h7B, 8'h9D, 8'hAA};
    int acc_cyc [$];
    logic [3:0] results [$];
    int idx, pulses;
    logic prev;
    idx = 0; pulses = 0; prev = crst8;
    iv8 = 1'b1; rr8 = 1'b1;
    for (int c = 0; c < 42; c++) begin
      if (crst8 === 1'b1 && prev !== 1'b1) pulses++;
      prev = crst8;
      if (rv8 === 1'b1) results.push_back(res8);
      if (ir8 === 1'b1) begin
        if (idx < 3) begin
          g8 = gp[idx]; e8 = ep[idx];
          acc_cyc.push_back(c);
          idx++;
        end else begin
          iv8 = 1'b0;
        end
      end
      step();
    end
    iv8 = 1'b0; rr8 = 1'b0;
    checks++;
    if (acc_cyc.size() !== 3 || acc_cyc[1] - acc_cyc[0] !== 12 || acc_cyc[2] - acc_cyc[1] !== 12) begin
      errors++;
      $display("FAIL b2b_period: %0d accepts, spacing %0d %0d expected 3 accepts spacing 12 12",
               acc_cyc.size(), acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1,
               acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : -1);
    end
    checks++;
    if (pulses !== 3) begin
      errors++; $display("FAIL b2b_core_rst: got %0d pulses expected 3", pulses);
    end
    checks++;
    if (results.size() !== 3 || results[0] !== 4'd4 || results[1] !== 4'd5 || results[2] !== 4'd0) begin
      errors++;
      $display("FAIL b2b_results: got %0d results first=%0d expected 3 results 4 5 0",
               results.size(), results.size() > 0 ? results[0] : 4'd15);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_cc4();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
